// File: rtl/mat_pkg.sv
// Shared widths, FSM state encoding and row extraction helper for the matrix row streamer.
package mat_pkg;

    localparam int ELEM_W = 8;
    localparam int N_ROWS = 5;
    localparam int N_COLS = 5;
    localparam int ROW_W  = N_COLS * ELEM_W;
    localparam int MAT_W  = N_ROWS * ROW_W;
    localparam int IDX_W  = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Row 0 occupies the most significant ROW_W bits of the packed matrix.
    function automatic logic [ROW_W-1:0] row_sel(input logic [MAT_W-1:0] mat,
                                                 input logic [IDX_W-1:0] idx);
        logic [ROW_W-1:0] row;
        row = '0;
        for (int r = 0; r < N_ROWS; r++) begin
            if (idx == IDX_W'(r)) row = mat[MAT_W-1-r*ROW_W -: ROW_W];
        end
        return row;
    endfunction

endpackage

// File: rtl/row_neg_ovf_chk.sv
// Combinational scan of one packed row for the most-negative element value,
// whose two's-complement negation does not fit in the element width.
module row_neg_ovf_chk
    import mat_pkg::*;
(
    input  logic [ROW_W-1:0] row_i,
    output logic             ovf_o
);

    localparam logic [ELEM_W-1:0] MOST_NEG = {1'b1, {(ELEM_W-1){1'b0}}};

    always_comb begin
        ovf_o = 1'b0;
        for (int c = 0; c < N_COLS; c++) begin
            if (row_i[ROW_W-1-c*ELEM_W -: ELEM_W] == MOST_NEG) ovf_o = 1'b1;
        end
    end

endmodule

// File: rtl/mat_row_stream.sv
// Latches a packed matrix on start, streams it row by row to an external row unit
// over a req/ack handshake and assembles the returned rows into a result matrix.
module mat_row_stream
    import mat_pkg::*;
#(
    parameter bit CHK_NEG_OVF = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [MAT_W-1:0] mat_in,
    output logic             busy,
    output logic             done,
    output logic [MAT_W-1:0] mat_out,
    output logic             neg_ovf,
    output logic             row_req,
    output logic [IDX_W-1:0] row_idx,
    output logic [ROW_W-1:0] row_data,
    input  logic             row_ack,
    input  logic [ROW_W-1:0] row_res
);

    state_e           state_q, state_d;
    logic [MAT_W-1:0] src_q, src_d;
    logic [MAT_W-1:0] res_q, res_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             ovf_q, ovf_d;
    logic             row_ovf;

    assign row_data = row_sel(src_q, idx_q);
    assign row_idx  = idx_q;
    assign mat_out  = res_q;
    assign neg_ovf  = ovf_q;
    assign busy     = (state_q == ST_ISSUE);
    assign row_req  = (state_q == ST_ISSUE);
    assign done     = (state_q == ST_DONE);

    row_neg_ovf_chk u_chk (
        .row_i (row_data),
        .ovf_o (row_ovf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            src_q   <= '0;
            res_q   <= '0;
            idx_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            res_q   <= res_d;
            idx_q   <= idx_d;
            ovf_q   <= ovf_d;
        end
    end

    // The row index only advances on an accepted row; it is reset to 0 only by a new start.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        res_d   = res_q;
        idx_d   = idx_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    src_d   = mat_in;
                    idx_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (row_ack) begin
                    for (int r = 0; r < N_ROWS; r++) begin
                        if (idx_q == IDX_W'(r)) res_d[MAT_W-1-r*ROW_W -: ROW_W] = row_res;
                    end
                    if (CHK_NEG_OVF && row_ovf) ovf_d = 1'b1;
                    if (idx_q == IDX_W'(N_ROWS-1)) state_d = ST_DONE;
                    else                           idx_d   = idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mat_row_stream.sv
// Directed bench for mat_row_stream with a negate row unit whose ack is either
// tied to req or delayed by three wait cycles per row.
module tb_mat_row_stream;
    import mat_pkg::*;

    logic             clk;
    logic             rst;
    logic             start;
    logic [MAT_W-1:0] matIn;
    logic             busy;
    logic             done;
    logic [MAT_W-1:0] matOut;
    logic             negOvf;
    logic             rowReq;
    logic [IDX_W-1:0] rowIdx;
    logic [ROW_W-1:0] rowData;
    logic             rowAck;
    logic [ROW_W-1:0] rowRes;

    int vectors     = 0;
    int miscompares = 0;
    int doneCount   = 0;
    int waitCnt     = 0;
    int ackMode     = 0;

    mat_row_stream #(.CHK_NEG_OVF(1'b1)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .mat_in   (matIn),
        .busy     (busy),
        .done     (done),
        .mat_out  (matOut),
        .neg_ovf  (negOvf),
        .row_req  (rowReq),
        .row_idx  (rowIdx),
        .row_data (rowData),
        .row_ack  (rowAck),
        .row_res  (rowRes)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [ROW_W-1:0] negRow(input logic [ROW_W-1:0] row);
        logic [ROW_W-1:0] res;
        res = '0;
        for (int c = 0; c < N_COLS; c++) res[ROW_W-1-c*ELEM_W -: ELEM_W] = 8'h00 - row[ROW_W-1-c*ELEM_W -: ELEM_W];
        return res;
    endfunction

    function automatic logic [MAT_W-1:0] negMat(input logic [MAT_W-1:0] m);
        logic [MAT_W-1:0] res;
        res = '0;
        for (int k = 0; k < N_ROWS*N_COLS; k++) res[MAT_W-1-k*ELEM_W -: ELEM_W] = 8'h00 - m[MAT_W-1-k*ELEM_W -: ELEM_W];
        return res;
    endfunction

    function automatic logic [MAT_W-1:0] seqMat(input int base);
        logic [MAT_W-1:0] res;
        res = '0;
        for (int k = 0; k < N_ROWS*N_COLS; k++) res[MAT_W-1-k*ELEM_W -: ELEM_W] = ELEM_W'(base + k);
        return res;
    endfunction

    function automatic logic [ROW_W-1:0] rowOf(input logic [MAT_W-1:0] m, input int r);
        return m[MAT_W-1-r*ROW_W -: ROW_W];
    endfunction

    function automatic logic [MAT_W-1:0] setRow(input logic [MAT_W-1:0] m, input int r, input logic [ROW_W-1:0] row);
        logic [MAT_W-1:0] res;
        res = m;
        res[MAT_W-1-r*ROW_W -: ROW_W] = row;
        return res;
    endfunction

    // Negate unit: combinational result, ack either follows req or waits three cycles per row.
    assign rowRes = negRow(rowData);
    assign rowAck = (ackMode == 0) ? rowReq : ((ackMode == 1) && rowReq && (waitCnt == 3));

    always @(posedge clk) begin
        waitCnt <= (rowReq && !rowAck) ? waitCnt + 1 : 0;
        if (done === 1'b1) doneCount <= doneCount + 1;
    end

    task automatic checkOutput(input string tag, input logic [MAT_W-1:0] observed, input logic [MAT_W-1:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic checkBit(input string tag, input logic observed, input logic expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [MAT_W-1:0] mat);
        matIn = mat;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts rising edges since the start edge (which is edge 1) until done is seen.
    task automatic waitDone(input int firstEdge, input int maxEdges, output int edges);
        edges = firstEdge;
        while (done !== 1'b1 && edges < maxEdges) begin
            @(negedge clk);
            edges++;
        end
    endtask

    logic [MAT_W-1:0] matA, matB, matE, matP, matQ, matY, matZ, expect0;
    int edges;
    int doneBase;

    initial begin
        matA = seqMat(1);
        matB = '0;
        matB[MAT_W-1-13*ELEM_W -: ELEM_W] = 8'h80;
        matE = matA;
        matE[MAT_W-1 -: ELEM_W] = 8'h80;
        matP = seqMat(32);
        matQ = '0;
        for (int k = 0; k < N_ROWS*N_COLS; k++) matQ[MAT_W-1-k*ELEM_W -: ELEM_W] = 8'h80;
        matZ = matQ;
        matY = seqMat(64);

        rst = 1'b1;
        start = 1'b0;
        matIn = '0;
        ackMode = 0;
        @(negedge clk);
        checkBit("reset busy", busy, 1'b0);
        checkBit("reset done", done, 1'b0);
        checkBit("reset rowReq", rowReq, 1'b0);
        checkOutput("reset rowIdx", MAT_W'(rowIdx), '0);
        checkOutput("reset rowData", MAT_W'(rowData), '0);
        checkOutput("reset matOut", matOut, '0);
        checkBit("reset negOvf", negOvf, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] elements 1..25, ack tied to req");
        doneBase = doneCount;
        applyStimulus(matA);
        checkBit("A busy", busy, 1'b1);
        checkBit("A rowReq", rowReq, 1'b1);
        checkOutput("A rowIdx", MAT_W'(rowIdx), '0);
        checkOutput("A rowData0", MAT_W'(rowData), MAT_W'(40'h0102030405));
        waitDone(1, 40, edges);
        // The start cycle is cycle 1, so done in cycle 7 is six edges after it.
        checkOutput("A latency", MAT_W'(edges), MAT_W'(6));
        checkBit("A done", done, 1'b1);
        checkBit("A busy at done", busy, 1'b0);
        checkBit("A rowReq at done", rowReq, 1'b0);
        checkOutput("A matOut", matOut, negMat(matA));
        checkOutput("A row0", MAT_W'(rowOf(matOut, 0)), MAT_W'(40'hFFFEFDFCFB));
        checkOutput("A row4", MAT_W'(rowOf(matOut, 4)), MAT_W'(40'hEBEAE9E8E7));
        checkBit("A negOvf", negOvf, 1'b0);
        @(negedge clk);
        checkBit("A done pulse", done, 1'b0);
        checkOutput("A matOut hold", matOut, negMat(matA));
        checkOutput("A done count", MAT_W'(doneCount - doneBase), MAT_W'(1));

        $display("[TB] single 8'h80 at row2 col3");
        applyStimulus(matB);
        waitDone(1, 40, edges);
        checkOutput("B latency", MAT_W'(edges), MAT_W'(6));
        checkBit("B negOvf at done", negOvf, 1'b1);
        checkOutput("B matOut", matOut, matB);
        checkOutput("B row2", MAT_W'(rowOf(matOut, 2)), MAT_W'(40'h0000008000));
        repeat (3) @(negedge clk);
        checkBit("B negOvf held", negOvf, 1'b1);
        checkOutput("B matOut held", matOut, matB);

        $display("[TB] ack delayed three cycles per row");
        ackMode = 1;
        doneBase = doneCount;
        applyStimulus(matA);
        checkBit("C negOvf cleared", negOvf, 1'b0);
        for (int r = 0; r < N_ROWS; r++) begin
            for (int w = 0; w < 4; w++) begin
                checkOutput($sformatf("C rowIdx r%0d w%0d", r, w), MAT_W'(rowIdx), MAT_W'(r));
                checkOutput($sformatf("C rowData r%0d w%0d", r, w), MAT_W'(rowData), MAT_W'(rowOf(matA, r)));
                @(negedge clk);
            end
        end
        checkBit("C done at 1+5*4+1", done, 1'b1);
        checkOutput("C matOut", matOut, negMat(matA));
        checkOutput("C done count", MAT_W'(doneCount - doneBase), MAT_W'(0));
        @(negedge clk);
        checkOutput("C done count after", MAT_W'(doneCount - doneBase), MAT_W'(1));
        ackMode = 0;

        $display("[TB] start pulsed again during ISSUE");
        doneBase = doneCount;
        applyStimulus(matP);
        matIn = matQ;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitDone(2, 40, edges);
        checkOutput("D latency", MAT_W'(edges), MAT_W'(6));
        checkOutput("D matOut", matOut, negMat(matP));
        checkOutput("D row0", MAT_W'(rowOf(matOut, 0)), MAT_W'(40'hE0DFDEDDDC));
        checkBit("D negOvf", negOvf, 1'b0);
        repeat (4) @(negedge clk);
        checkOutput("D done count", MAT_W'(doneCount - doneBase), MAT_W'(1));

        $display("[TB] asynchronous reset at row 2");
        applyStimulus(matE);
        @(negedge clk);
        @(negedge clk);
        checkOutput("E rowIdx before rst", MAT_W'(rowIdx), MAT_W'(2));
        checkBit("E negOvf before rst", negOvf, 1'b1);
        doneBase = doneCount;
        #2 rst = 1'b1;
        #1;
        checkBit("E busy in rst", busy, 1'b0);
        checkBit("E rowReq in rst", rowReq, 1'b0);
        checkBit("E done in rst", done, 1'b0);
        checkBit("E negOvf in rst", negOvf, 1'b0);
        checkOutput("E matOut in rst", matOut, '0);
        checkOutput("E rowData in rst", MAT_W'(rowData), '0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkBit("E idle after rst", busy, 1'b0);
        checkOutput("E no done", MAT_W'(doneCount - doneBase), MAT_W'(0));
        applyStimulus(matA);
        waitDone(1, 40, edges);
        checkOutput("E latency", MAT_W'(edges), MAT_W'(6));
        checkOutput("E matOut", matOut, negMat(matA));
        checkBit("E negOvf", negOvf, 1'b0);

        $display("[TB] start in DONE ignored, then back-to-back start");
        matIn = matZ;
        start = 1'b1;
        @(negedge clk);
        checkBit("F start in DONE ignored", busy, 1'b0);
        checkOutput("F matOut kept", matOut, negMat(matA));
        matIn = matY;
        @(negedge clk);
        start = 1'b0;
        checkBit("F busy", busy, 1'b1);
        checkOutput("F rowData0", MAT_W'(rowData), MAT_W'(rowOf(matY, 0)));
        checkOutput("F matOut before row0", matOut, negMat(matA));
        @(negedge clk);
        expect0 = setRow(negMat(matA), 0, negRow(rowOf(matY, 0)));
        checkOutput("F matOut after row0", matOut, expect0);
        waitDone(2, 40, edges);
        checkOutput("F latency", MAT_W'(edges), MAT_W'(6));
        checkOutput("F matOut", matOut, negMat(matY));
        checkBit("F negOvf", negOvf, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
